// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DSTART = 2'd1,
        S_DWAIT  = 2'd2,
        S_MUL    = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: local multiply, handshake to the external 32-cycle divider,
// MTHI/MTLO writes and pipeline stall while an operation is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_sign,
    output logic             div_start,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    state_e               state_r;
    state_e               next_state_s;
    logic                 accept_mul_s;
    logic                 accept_div_s;
    logic                 wr_hi_s;
    logic                 wr_lo_s;
    logic                 div_done_s;
    logic [WIDTH-1:0]     mul_a_r;
    logic [WIDTH-1:0]     mul_b_r;
    logic                 mul_sign_r;
    logic [2*WIDTH-1:0]   mul_a_ext_s;
    logic [2*WIDTH-1:0]   mul_b_ext_s;
    logic [2*WIDTH-1:0]   prod_s;

    // Decode the presented op and compute the next sequencer state.
    always_comb begin
        next_state_s = state_r;
        accept_mul_s = 1'b0;
        accept_div_s = 1'b0;
        wr_hi_s      = 1'b0;
        wr_lo_s      = 1'b0;
        div_done_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            accept_mul_s = 1'b1;
                            next_state_s = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept_div_s = 1'b1;
                            next_state_s = S_DSTART;
                        end
                        OP_MTHI: wr_hi_s = 1'b1;
                        OP_MTLO: wr_lo_s = 1'b1;
                        default: next_state_s = S_IDLE;
                    endcase
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_DSTART: next_state_s = S_DWAIT;
            // Busy is already high on entry here, so its first low cycle is completion.
            S_DWAIT: begin
                if (!div_busy) begin
                    div_done_s   = 1'b1;
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DWAIT;
                end
            end
            S_MUL:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Sign- or zero-extend both latched operands so one 64-bit multiply serves MULT and MULTU.
    always_comb begin
        mul_a_ext_s = {{WIDTH{mul_sign_r & mul_a_r[WIDTH-1]}}, mul_a_r};
        mul_b_ext_s = {{WIDTH{mul_sign_r & mul_b_r[WIDTH-1]}}, mul_b_r};
        prod_s      = mul_a_ext_s * mul_b_ext_s;
    end

    assign stall = (state_r != S_IDLE) & (op_valid | hilo_rd);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latches; divider inputs stay frozen until the next divide is accepted
    // because the divider sign-corrects from them when it delivers its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_r      <= {WIDTH{1'b0}};
            mul_b_r      <= {WIDTH{1'b0}};
            mul_sign_r   <= 1'b0;
            div_dividend <= {WIDTH{1'b0}};
            div_divisor  <= {WIDTH{1'b0}};
            div_sign     <= 1'b0;
            div_start    <= 1'b0;
        end else begin
            div_start <= accept_div_s;
            if (accept_mul_s) begin
                mul_a_r    <= rs_val;
                mul_b_r    <= rt_val;
                mul_sign_r <= (op == OP_MULT);
            end
            if (accept_div_s) begin
                div_dividend <= rs_val;
                div_divisor  <= rt_val;
                div_sign     <= (op == OP_DIV);
            end
        end
    end

    // Architectural HI/LO update from multiply, divider capture or move-to.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= {WIDTH{1'b0}};
            lo <= {WIDTH{1'b0}};
        end else if (state_r == S_MUL) begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
        end else if (div_done_s) begin
            lo <= div_q;
            hi <= div_r;
        end else begin
            if (wr_hi_s) begin
                hi <= rs_val;
            end
            if (wr_lo_s) begin
                lo <= rs_val;
            end
        end
    end

endmodule
